// File: rtl/scene_pkg.sv
// scene_pkg: shared types, colours and brick-field geometry for scene_renderer.
package scene_pkg;
  typedef enum logic {IDLE, REQ} state_e;
  typedef logic [23:0] rgb_t;
  typedef struct packed {
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] plat_x;
    logic [9:0] plat_y;
    logic [9:0] gad_x;
    logic [9:0] gad_y;
    logic [1:0] gad_type;
    logic [31:0] bricks;
  } snap_t;
  localparam rgb_t BALL_RGB  = 24'hFFFFFF;
  localparam rgb_t PLAT_RGB  = 24'h00FF00;
  localparam rgb_t BRICK_RGB = 24'hFF8000;
  localparam rgb_t BG_RGB    = 24'h000000;
  localparam logic [9:0] BRICK_X0 = 10'd64;
  localparam logic [9:0] BRICK_Y0 = 10'd32;
  localparam logic [9:0] BRICK_W  = 10'd64;
  localparam logic [9:0] BRICK_H  = 10'd16;
  localparam int BRICK_COLS = 8;
  localparam int BRICK_ROWS = 4;
  localparam logic [9:0] BRICK_X1 = BRICK_X0 + 10'(BRICK_COLS) * BRICK_W;
  localparam logic [9:0] BRICK_Y1 = BRICK_Y0 + 10'(BRICK_ROWS) * BRICK_H;
  function automatic rgb_t gadget_rgb(input logic [1:0] t);
    return t == 2'd0 ? 24'hFF0000 : t == 2'd1 ? 24'hFFFF00 : t == 2'd2 ? 24'h00FFFF : 24'hFF00FF;
  endfunction
endpackage

// File: rtl/obj_hit.sv
// obj_hit: half-open box test; sums are 11 bits so boxes near 1023 clip instead of wrapping.
module obj_hit #(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] ox,
  input  logic [9:0] oy,
  output logic       hit
);
  assign hit = px >= ox && {1'b0, px} < {1'b0, ox} + 11'(W) &&
               py >= oy && {1'b0, py} < {1'b0, oy} + 11'(H);
endmodule

// File: rtl/scene_renderer.sv
// scene_renderer: snapshots game-object positions via a req/ack handshake in vblank
// and renders ball, gadget, platform and bricks through a 2-stage pixel pipeline.
module scene_renderer
  import scene_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int BALL_SZ = 8,
  parameter int PLAT_W  = 64,
  parameter int PLAT_H  = 8,
  parameter int GAD_SZ  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  input  logic       vga_active,
  input  logic       vga_vblank_start,
  output logic       frame_req,
  input  logic       frame_ack,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] plat_x,
  input  logic [9:0] plat_y,
  input  logic [9:0] gadget_x,
  input  logic [9:0] gadget_y,
  input  logic [1:0] gadget_type,
  input  logic [31:0] brick_map,
  output logic [7:0] pix_r,
  output logic [7:0] pix_g,
  output logic [7:0] pix_b,
  output logic       pix_valid,
  output logic       snap_valid,
  output logic       timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  snap_t snap_q, snap_d;
  logic snap_valid_q, snap_valid_d, timeout_q, timeout_d;
  logic ball_h, gad_h, plat_h, brick_h, brick_area;
  logic [4:0] brick_idx;
  logic [3:0] hit_q, hit_d;
  logic act_q1, pix_valid_q;
  logic [1:0] gt_q1;
  rgb_t pix_q, rgb_d;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    snap_d = snap_q;
    snap_valid_d = snap_valid_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = vga_vblank_start ? REQ : IDLE;
      cnt_d = '0;
    end else if (frame_ack) begin
      state_d = IDLE;
      snap_d = '{ball_x, ball_y, plat_x, plat_y, gadget_x, gadget_y, gadget_type, brick_map};
      snap_valid_d = 1'b1;
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  obj_hit #(.W(BALL_SZ), .H(BALL_SZ)) u_ball (
    .px(vga_x), .py(vga_y), .ox(snap_q.ball_x), .oy(snap_q.ball_y), .hit(ball_h));
  obj_hit #(.W(GAD_SZ), .H(GAD_SZ)) u_gad (
    .px(vga_x), .py(vga_y), .ox(snap_q.gad_x), .oy(snap_q.gad_y), .hit(gad_h));
  obj_hit #(.W(PLAT_W), .H(PLAT_H)) u_plat (
    .px(vga_x), .py(vga_y), .ox(snap_q.plat_x), .oy(snap_q.plat_y), .hit(plat_h));

  // index = row*8 + col, with row in the upper two bits
  assign brick_area = vga_x >= BRICK_X0 && vga_x < BRICK_X1 && vga_y >= BRICK_Y0 && vga_y < BRICK_Y1;
  assign brick_idx = {2'((vga_y - BRICK_Y0) >> $clog2(BRICK_H)), 3'((vga_x - BRICK_X0) >> $clog2(BRICK_W))};
  assign brick_h = brick_area && snap_q.bricks[brick_idx];
  assign hit_d = snap_valid_q ? {ball_h, gad_h, plat_h, brick_h} : 4'b0;

  always_comb begin
    rgb_d = !act_q1 ? BG_RGB : hit_q[3] ? BALL_RGB : hit_q[2] ? gadget_rgb(gt_q1) :
            hit_q[1] ? PLAT_RGB : hit_q[0] ? BRICK_RGB : BG_RGB;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      snap_q <= '0;
      snap_valid_q <= 1'b0;
      timeout_q <= 1'b0;
      hit_q <= '0;
      act_q1 <= 1'b0;
      gt_q1 <= '0;
      pix_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      snap_q <= snap_d;
      snap_valid_q <= snap_valid_d;
      timeout_q <= timeout_d;
      hit_q <= hit_d;
      act_q1 <= vga_active;
      gt_q1 <= snap_q.gad_type;
      pix_q <= rgb_d;
      pix_valid_q <= act_q1;
    end
  end

  assign frame_req = state_q == REQ;
  assign snap_valid = snap_valid_q;
  assign timeout_err = timeout_q;
  assign {pix_r, pix_g, pix_b} = pix_q;
  assign pix_valid = pix_valid_q;
endmodule

// File: tb/tb_scene_renderer.sv
// tb_scene_renderer: scoreboard bench; a driver pushes model-predicted pixels with their due cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_scene_renderer;
  logic clk = 1'b0, rst = 1'b0;
  logic [9:0] vga_x = '0, vga_y = '0;
  logic vga_active = 1'b0, vga_vblank_start = 1'b0, frame_ack = 1'b0;
  logic [9:0] ball_x = '0, ball_y = '0, plat_x = '0, plat_y = '0, gadget_x = '0, gadget_y = '0;
  logic [1:0] gadget_type = '0;
  logic [31:0] brick_map = '0;
  logic frame_req, pix_valid, snap_valid, timeout_err;
  logic [7:0] pix_r, pix_g, pix_b;

  scene_renderer dut (
    .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_active(vga_active),
    .vga_vblank_start(vga_vblank_start), .frame_req(frame_req), .frame_ack(frame_ack),
    .ball_x(ball_x), .ball_y(ball_y), .plat_x(plat_x), .plat_y(plat_y),
    .gadget_x(gadget_x), .gadget_y(gadget_y), .gadget_type(gadget_type), .brick_map(brick_map),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
    .snap_valid(snap_valid), .timeout_err(timeout_err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int m_bx, m_by, m_px, m_py, m_gx, m_gy, m_gt;
  logic [31:0] m_bricks;
  bit m_sv = 0;

  typedef struct {int due; logic v; logic [23:0] rgb;} exp_t;
  exp_t sb[$];
  exp_t e;

  function automatic bit in_box(int x, int y, int ox, int oy, int w, int h);
    return x >= ox && x < ox + w && y >= oy && y < oy + h;
  endfunction

  function automatic logic [23:0] gad_colour(int t);
    case (t)
      0: return 24'hFF0000;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      default: return 24'hFF00FF;
    endcase
  endfunction

  function automatic logic [23:0] model_rgb(int x, int y);
    if (!m_sv) return 24'h0;
    if (in_box(x, y, m_bx, m_by, 8, 8)) return 24'hFFFFFF;
    if (in_box(x, y, m_gx, m_gy, 8, 8)) return gad_colour(m_gt);
    if (in_box(x, y, m_px, m_py, 64, 8)) return 24'h00FF00;
    if (x >= 64 && x < 576 && y >= 32 && y < 96 && m_bricks[((y - 32) / 16) * 8 + (x - 64) / 64])
      return 24'hFF8000;
    return 24'h0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input bit act);
    vga_x = 10'(x);
    vga_y = 10'(y);
    vga_active = act;
    sb.push_back('{cyc + 2, act, act ? model_rgb(x, y) : 24'h0});
    step();
  endtask

  task automatic drain();
    vga_active = 1'b0;
    repeat (4) step();
  endtask

  task automatic set_objs(input int bx, input int by, input int px, input int py,
                          input int gx, input int gy, input int gt, input logic [31:0] bm);
    ball_x = 10'(bx); ball_y = 10'(by); plat_x = 10'(px); plat_y = 10'(py);
    gadget_x = 10'(gx); gadget_y = 10'(gy); gadget_type = 2'(gt); brick_map = bm;
  endtask

  task automatic snapshot(input int ack_after);
    int n;
    vga_vblank_start = 1'b1;
    step();
    vga_vblank_start = 1'b0;
    n = 0;
    for (int i = 0; i < ack_after - 1; i++) begin
      if (frame_req) n++;
      step();
    end
    if (frame_req) n++;
    frame_ack = 1'b1;
    m_bx = ball_x; m_by = ball_y; m_px = plat_x; m_py = plat_y;
    m_gx = gadget_x; m_gy = gadget_y; m_gt = gadget_type; m_bricks = brick_map; m_sv = 1;
    step();
    frame_ack = 1'b0;
    chk("req_cycles", n, ack_after);
    chk("req_drop_after_ack", frame_req, 0);
    chk("snap_valid_set", snap_valid, 1);
  endtask

  function automatic int clip(int v);
    return v < 0 ? 0 : v > 1023 ? 1023 : v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL pix_missed: due cycle %0d never presented (now %0d)", e.due, cyc);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checks++;
        if (pix_valid !== e.v || {pix_r, pix_g, pix_b} !== e.rgb) begin
          errors++;
          $display("FAIL pixel: got valid=%0b rgb=%06h expected valid=%0b rgb=%06h (cycle %0d)",
                   pix_valid, {pix_r, pix_g, pix_b}, e.v, e.rgb, cyc);
        end
      end else begin
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_valid: got pix_valid=%0b expected 0 (cycle %0d)", pix_valid, cyc);
        end
      end
    end
  end

  initial begin
    int n, mode, x, y;
    set_objs(5, 5, 40, 40, 80, 80, 1, 32'hFFFF_FFFF);
    vga_vblank_start = 1'b1;
    frame_ack = 1'b1;
    repeat (3) step();
    vga_vblank_start = 1'b0;
    frame_ack = 1'b0;
    chk("rst_frame_req", frame_req, 0);
    chk("rst_snap_valid", snap_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_rgb", {pix_r, pix_g, pix_b}, 0);
    rst = 1'b1;
    step();
    repeat (3) begin
      chk("no_req_without_vblank", frame_req, 0);
      step();
    end
    pix(0, 0, 1); pix(3, 3, 1); pix(70, 40, 1);
    drain();

    set_objs(100, 200, 600, 450, 900, 50, 0, 32'h0);
    snapshot(3);
    pix(100, 200, 1); pix(108, 200, 1); pix(107, 207, 1); pix(100, 208, 1); pix(100, 200, 0);
    pix(903, 53, 1); pix(620, 455, 1);
    drain();

    set_objs(500, 400, 10, 10, 10, 10, 3, 32'hFFFF_FFFF);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("idle_ack_no_req", frame_req, 0);
    pix(100, 200, 1); pix(500, 400, 1); pix(64, 32, 1);
    drain();

    set_objs(600, 400, 10, 10, 10, 10, 3, 32'hFFFF_FFFF);
    vga_vblank_start = 1'b1;
    step();
    vga_vblank_start = 1'b0;
    n = 0;
    while (frame_req === 1'b1 && n < 2000) begin
      n++;
      vga_vblank_start = (n == 500);
      if (timeout_err) chk("early_timeout", timeout_err, 0);
      step();
    end
    vga_vblank_start = 1'b0;
    chk("timeout_len", n, 1024);
    chk("timeout_pulse", timeout_err, 1);
    chk("timeout_req_low", frame_req, 0);
    step();
    chk("timeout_pulse_end", timeout_err, 0);
    chk("snap_kept", snap_valid, 1);
    pix(100, 200, 1); pix(600, 400, 1); pix(64, 32, 1);
    drain();

    set_objs(300, 300, 296, 296, 1020, 10, 2, 32'h0000_0001);
    snapshot(2);
    pix(300, 300, 1); pix(296, 296, 1); pix(64, 32, 1); pix(128, 32, 1); pix(63, 32, 1);
    pix(1023, 10, 1); pix(0, 10, 1); pix(1019, 10, 1); pix(127, 47, 1); pix(127, 48, 1);
    drain();

    for (int r = 0; r < 6; r++) begin
      set_objs($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 3), $urandom());
      if (r == 0) begin ball_x = 10'd1020; ball_y = 10'd1021; end
      snapshot($urandom_range(1, 10));
      for (int i = 0; i < 80; i++) begin
        mode = $urandom_range(0, 4);
        case (mode)
          0: begin x = m_bx + $urandom_range(0, 11) - 2; y = m_by + $urandom_range(0, 11) - 2; end
          1: begin x = m_gx + $urandom_range(0, 11) - 2; y = m_gy + $urandom_range(0, 11) - 2; end
          2: begin x = m_px + $urandom_range(0, 67) - 2; y = m_py + $urandom_range(0, 11) - 2; end
          3: begin x = $urandom_range(56, 583); y = $urandom_range(24, 103); end
          default: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
        endcase
        pix(clip(x), clip(y), $urandom_range(0, 7) != 0);
      end
      drain();
    end

    vga_vblank_start = 1'b1;
    step();
    vga_vblank_start = 1'b0;
    chk("req_rise", frame_req, 1);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_req", frame_req, 0);
    chk("rst_mid_timeout", timeout_err, 0);
    chk("rst_mid_snap", snap_valid, 0);
    chk("rst_mid_pix_valid", pix_valid, 0);
    m_sv = 0;
    step();
    rst = 1'b1;
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    repeat (5) begin
      chk("post_rst_req", frame_req, 0);
      chk("post_rst_snap", snap_valid, 0);
      chk("post_rst_timeout", timeout_err, 0);
      step();
    end
    pix(0, 0, 1); pix(300, 300, 1); pix(64, 32, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
